// File: rtl/wd_servicer_if.sv
// Signal bundle between the watchdog servicer and its host/watchdog.
// Master drives config, kick and watchdog status; slave is the servicer.
interface wd_servicer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_start;
    logic        kick_req;
    logic        clr_fault;
    logic        wd_int;
    logic        wd_timeout;
    logic        wd_flag;
    logic [1:0]  wd_mode;
    logic        wd_update;
    logic [31:0] wd_start;
    logic        fault;
    logic [7:0]  fail_cnt;

    modport master (
        output cfg_valid, cfg_mode, cfg_start, kick_req, clr_fault,
        output wd_int, wd_timeout,
        input  cfg_ready, wd_flag, wd_mode, wd_update, wd_start,
        input  fault, fail_cnt
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_start, kick_req, clr_fault,
        input  wd_int, wd_timeout,
        output cfg_ready, wd_flag, wd_mode, wd_update, wd_start,
        output fault, fail_cnt
    );
endinterface

// File: rtl/wd_servicer.sv
// Watchdog servicer: loads config, auto-kicks after a pre-timeout
// interrupt and escalates repeated timeouts into a sticky fault.
module wd_servicer #(
    parameter int unsigned KICK_DELAY = 4,
    parameter int unsigned MAX_FAIL   = 3
) (
    input  logic         clk,
    input  logic         rst_,
    wd_servicer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ARMED, KICK, FAULT} state_t;

    localparam logic [7:0] KD = 8'(KICK_DELAY);
    localparam logic [7:0] MF = 8'(MAX_FAIL);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  mode_q;
    logic [31:0] start_q;
    logic        int_q;
    logic        to_q;
    logic        pend;
    logic [7:0]  dly;
    logic [7:0]  fail_q;
    logic [7:0]  fail_inc;
    logic        int_edge;
    logic        to_edge;
    logic        to_event;
    logic        active;
    logic        xfer;
    logic        flag;
    logic        upd;
    logic        flt;
    logic [1:0]  mode;

    assign int_edge = bus.wd_int & ~int_q;
    assign to_edge  = bus.wd_timeout & ~to_q;
    assign active   = (state == LOAD) | (state == ARMED) | (state == KICK);
    assign to_event = (state == ARMED) & (pend | to_edge);
    assign fail_inc = (fail_q == 8'hff) ? fail_q : fail_q + 8'd1;

    // Ready drops while a timeout is being consumed so it cannot race a reload.
    assign bus.cfg_ready = rst_ & ((state == IDLE) | (state == ARMED))
                         & ~to_event;
    assign xfer = bus.cfg_valid & bus.cfg_ready;

    always_comb begin
        state_nx = state;
        flag     = 1'b0;
        upd      = 1'b0;
        flt      = 1'b0;
        mode     = {1'b0, mode_q[0]};
        unique case (state)
            IDLE: begin
                if (xfer) state_nx = LOAD;
            end
            LOAD: begin
                upd      = 1'b1;
                mode     = mode_q;
                state_nx = ARMED;
            end
            ARMED: begin
                mode = mode_q;
                if (to_event)
                    state_nx = (fail_inc >= MF) ? FAULT : KICK;
                else if (xfer)
                    state_nx = LOAD;
                else if (bus.kick_req)
                    state_nx = KICK;
                else if (dly == 8'd1)
                    state_nx = KICK;
            end
            KICK: begin
                flag     = 1'b1;
                mode     = mode_q;
                state_nx = ARMED;
            end
            FAULT: begin
                flt = 1'b1;
                if (bus.clr_fault) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.wd_flag   = flag;
    assign bus.wd_update = upd;
    assign bus.wd_mode   = mode;
    assign bus.fault     = flt;
    assign bus.wd_start  = start_q;
    assign bus.fail_cnt  = fail_q;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state   <= IDLE;
            mode_q  <= 2'b00;
            start_q <= 32'hffff_ffff;
            int_q   <= 1'b0;
            to_q    <= 1'b0;
            pend    <= 1'b0;
            dly     <= 8'd0;
            fail_q  <= 8'd0;
        end else begin
            state <= state_nx;
            int_q <= bus.wd_int;
            to_q  <= bus.wd_timeout;
            if (xfer) begin
                mode_q  <= bus.cfg_mode;
                start_q <= bus.cfg_start;
            end
            if (state == ARMED)
                pend <= 1'b0;
            else if (state == FAULT && bus.clr_fault)
                pend <= 1'b0;
            else if (to_edge && active)
                pend <= 1'b1;
            if (to_event)
                fail_q <= fail_inc;
            else if (state == FAULT && bus.clr_fault)
                fail_q <= 8'd0;
            // Any kick, manual or timeout-driven, cancels a pending auto-kick.
            if (!active || state == KICK || state_nx == KICK)
                dly <= 8'd0;
            else if (int_edge && KD != 8'd0)
                dly <= KD;
            else if (dly != 8'd0)
                dly <= dly - 8'd1;
        end
    end
endmodule

// File: doc/wd_servicer.md
WD_SERVICER -- requirements
Module: wd_servicer

Interface
REQ-001 Parameter KICK_DELAY, default 4, cycles from sampled wd_int rising edge to auto-kick; 0 disables auto-kick; range 0..255.
REQ-002 Parameter MAX_FAIL, default 3, count of timeout events that forces FAULT; range 1..255.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_  in  1  reset, synchronous, active-low.
REQ-005 cfg_valid  in  1  configuration request.
REQ-006 cfg_ready  out  1  configuration accept; transfer occurs when cfg_valid and cfg_ready are both high at a posedge.
REQ-007 cfg_mode  in  2  requested watchdog mode; bit1 enable, bit0 modesel.
REQ-008 cfg_start  in  32  requested watchdog reload value.
REQ-009 kick_req  in  1  manual service request.
REQ-010 clr_fault  in  1  clears FAULT.
REQ-011 wd_int  in  1  watchdog pre-timeout interrupt.
REQ-012 wd_timeout  in  1  watchdog timeout.
REQ-013 wd_flag  out  1  watchdog kick pulse.
REQ-014 wd_mode  out  2  watchdog mode drive.
REQ-015 wd_update  out  1  watchdog reload pulse.
REQ-016 wd_start  out  32  watchdog reload value.
REQ-017 fault  out  1  sticky fault indicator.
REQ-018 fail_cnt  out  8  timeout events since last clear.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, ARMED, KICK and FAULT.
REQ-020 cfg_ready SHALL be high in IDLE and ARMED, except low in any cycle in which a timeout event is being processed (REQ-026).
REQ-021 IDLE: wd_mode[1]=0; on cfg transfer, latch cfg_mode into mode_q and cfg_start into wd_start, then go to LOAD.
REQ-022 LOAD: exactly one cycle; wd_update=1, wd_mode=mode_q; next state ARMED.
REQ-023 ARMED: wd_mode=mode_q; precedence is timeout event, then cfg transfer (to LOAD), then kick_req, then auto-kick expiry.
REQ-024 KICK: exactly one cycle; wd_flag=1; clears the auto-kick delay counter; next state ARMED.
REQ-025 wd_int and wd_timeout SHALL each be registered once; an edge is input=1 with its registered copy=0.
REQ-026 A timeout edge in any state other than IDLE/FAULT sets a pending bit, which ARMED consumes: fail_cnt increments (saturating at 255); next state FAULT if the new count >= MAX_FAIL, else KICK.
REQ-027 Auto-kick: a wd_int edge sampled at edge N loads the 8-bit delay counter with KICK_DELAY; the counter decrements at each edge while nonzero; ARMED with counter==1 goes to KICK; wd_flag is high in the cycle after edge N+KICK_DELAY.
REQ-028 Manual kick: kick_req sampled high in ARMED at edge N gives wd_flag high for one cycle, from edge N to edge N+1; any pending auto-kick is cancelled.
REQ-029 kick_req is ignored outside ARMED; it is not queued.
REQ-030 FAULT: wd_mode={1'b0, mode_q[0]}; fault=1; cfg_ready=0; kicks and edges ignored; clr_fault returns to IDLE and clears fail_cnt, fault and the pending bits.
REQ-031 wd_flag and wd_update SHALL never be high in the same cycle.
REQ-032 A cfg transfer in ARMED SHALL reload wd_start and mode_q without clearing fail_cnt.

Reset
REQ-033 While rst_=0 at a posedge, the block SHALL go to IDLE with wd_mode=2'b00, wd_start=32'hffffffff, wd_flag=0, wd_update=0, fault=0, fail_cnt=0, delay counter=0, pending and edge registers=0, and mode_q=2'b00.
REQ-034 Reset asserted mid-operation (any state, including during KICK or LOAD) SHALL take effect at the next posedge, with no trailing wd_flag or wd_update pulse.
REQ-035 cfg_ready SHALL be 0 in the cycle in which reset is sampled and 1 from the first non-reset cycle.

Verification
REQ-036 Cfg transfer with mode=2'b11, start=32'd100 -> one wd_update pulse next cycle, wd_start=100, wd_mode=2'b11, then ARMED.
REQ-037 ARMED, wd_int rises at edge N, KICK_DELAY=4 -> single wd_flag pulse in the cycle after edge N+4.
REQ-038 ARMED, kick_req at edge N with an auto-kick pending -> wd_flag once after edge N and no second pulse.
REQ-039 Three wd_timeout edges with MAX_FAIL=3 -> KICK, KICK, then FAULT; fail_cnt=3, fault=1, wd_mode[1]=0; clr_fault -> IDLE, fail_cnt=0.
REQ-040 Timeout edge and cfg_valid in the same ARMED cycle -> cfg_ready=0, no transfer, fail_cnt increments.
REQ-041 rst_=0 during KICK -> wd_flag=0 and all REQ-033 values at the next posedge.
